data_mem_mc: RTL and testbench



---
 rtl/data_mem_mc.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mc.sv
// data_mem_mc: multi-cycle word-organised data memory.
// Valid/ready request channel in front, valid/ready response channel out.
// Legal accesses complete LATENCY cycles after accept. Misaligned or
// out-of-range accesses raise exception flags and respond after one cycle.
// Optional feature macro: DATA_MEM_PERF_EN (adds load/store/exception counters).
module data_mem_mc #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 128,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
`ifdef DATA_MEM_PERF_EN
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       exc_cnt_o,
`endif
  output logic [1:0]        rsp_exc_o
);

  // Byte-offset bits inside one word, word-index width of the RAM.
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Captured request.
  logic               we_q;
  logic [1:0]         exc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;

  // Response registers.
  logic [1:0]         rsp_exc_q;
  logic               rd_sel_q;
  logic [DATA_W-1:0]  ram_rdata_q;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  // Control strobes from the next-state logic.
  logic               accept;
  logic               enter_resp;
  logic               ram_we;
  logic               ram_rd;
  logic               rsp_done;

  // Address classification of the incoming request.
  logic [1:0]         exc_in;
  logic [ADDR_W:0]    word_in;

  // Exception flags for the presented address: [0] misaligned, [1] out of range.
  always_comb begin
    word_in   = {1'b0, req_addr_i >> OFF_W};
    exc_in    = 2'b00;
    exc_in[0] = |(req_addr_i & OFF_MASK);
    exc_in[1] = (word_in >= (ADDR_W + 1)'(DEPTH));
  end

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    enter_resp  = 1'b0;
    ram_we      = 1'b0;
    ram_rd      = 1'b0;
    rsp_done    = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = WAIT;
          // Exceptions skip the access latency and respond on the next edge.
          cnt_d   = (|exc_in) ? '0 : CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          ram_we     = we_q & ~(|exc_q);
          ram_rd     = ~we_q & ~(|exc_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d  = IDLE;
          rsp_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture and response flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      exc_q     <= 2'b00;
      idx_q     <= '0;
      wdata_q   <= '0;
      rsp_exc_q <= 2'b00;
      rd_sel_q  <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        exc_q   <= exc_in;
        idx_q   <= req_addr_i[OFF_W +: IDX_W];
        wdata_q <= req_wdata_i;
      end
      if (enter_resp) begin
        rsp_exc_q <= exc_q;
        rd_sel_q  <= ram_rd;
      end
    end
  end

  // Block RAM: write port and registered read port. A store pending when
  // reset arrives is dropped, so the write is gated by rst.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
    if (ram_rd) begin
      ram_rdata_q <= mem_q[idx_q];
    end
  end

  // Stores and exceptions return zero data; loads return the captured word.
  assign rsp_rdata_o = rd_sel_q ? ram_rdata_q : '0;
  assign rsp_exc_o   = rsp_exc_q;

`ifdef DATA_MEM_PERF_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, exc_cnt_q;

  // Saturating event counters, stepped on each completed response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      exc_cnt_q <= '0;
    end else if (rsp_done) begin
      if (|rsp_exc_q) begin
        if (exc_cnt_q != 16'hFFFF) exc_cnt_q <= exc_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign exc_cnt_o = exc_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_mc.sv
// Testbench for data_mem_mc (default parameters). A word-array reference
// model predicts load data, exception flags and response latency.
module tb_data_mem_mc;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [1:0]        rsp_exc_o;
`ifdef DATA_MEM_PERF_EN
  logic [15:0]       rd_cnt_o, wr_cnt_o, exc_cnt_o;
  int                m_rd, m_wr, m_exc;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model [DEPTH];

  always #5 clk = ~clk;

  data_mem_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
`ifdef DATA_MEM_PERF_EN
    .rd_cnt_o(rd_cnt_o),
    .wr_cnt_o(wr_cnt_o),
    .exc_cnt_o(exc_cnt_o),
`endif
    .rsp_exc_o(rsp_exc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: issue, measure latency, check response,
  // optionally stall the consumer (and poke ignored requests), then release.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int hold, input logic poke);
    logic [1:0]        exp_exc;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_lat, lat, w;
    int                widx;
    widx      = int'(addr) / (DATA_W / 8);
    exp_exc   = {widx >= DEPTH, (int'(addr) % (DATA_W / 8)) != 0};
    exp_lat   = (exp_exc != 2'b00) ? 1 : LATENCY;
    exp_rdata = (exp_exc == 2'b00 && !we) ? model[widx] : '0;
    if (exp_exc == 2'b00 && we) model[widx] = wdata;

    w = 0;
    @(negedge clk);
    while (req_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("req_ready_busy", 32'(req_ready_o), 32'd0);
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rdata", rsp_rdata_o, exp_rdata);
    check("exc", 32'(rsp_exc_o), 32'(exp_exc));
    $display("txn we=%0d addr=%0h wdata=%0h -> lat=%0d rdata=%0h exc=%0b", we, addr, wdata, lat, rsp_rdata_o, rsp_exc_o);
`ifdef DATA_MEM_PERF_EN
    if (exp_exc != 2'b00) m_exc++; else if (we) m_wr++; else m_rd++;
`endif
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 10'h028;
        req_wdata_i = $urandom;
      end
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid_o), 32'd1);
      check("hold_rdata", rsp_rdata_o, exp_rdata);
      check("hold_exc", 32'(rsp_exc_o), 32'(exp_exc));
      check("hold_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    check("release_valid", 32'(rsp_valid_o), 32'd0);
    check("release_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                sel;
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0;
`ifdef DATA_MEM_PERF_EN
    m_rd = 0; m_wr = 0; m_exc = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_exc", 32'(rsp_exc_o), 32'd0);
    rst = 1'b0;

    // Fill every word so the model knows the whole RAM.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, ADDR_W'(i * 4), $urandom, 0, 1'b0);

    // Preload image equivalent: Mem[0]=4, Mem[4]=6, then load addr 4.
    do_req(1'b1, 10'd0, 32'd4, 0, 1'b0);
    do_req(1'b1, 10'd4, 32'd6, 0, 1'b0);
    do_req(1'b0, 10'd4, 32'd0, 0, 1'b0);
    do_req(1'b0, 10'd0, 32'd0, 0, 1'b0);
    // Store then load same word.
    do_req(1'b1, 10'd4, 32'd50, 0, 1'b0);
    do_req(1'b0, 10'd4, 32'd0, 0, 1'b0);
    // Misaligned load and store; store must not touch Mem[4].
    do_req(1'b0, 10'd5, 32'd0, 0, 1'b0);
    do_req(1'b1, 10'd6, 32'd77, 0, 1'b0);
    do_req(1'b0, 10'd4, 32'd0, 0, 1'b0);
    // Out of range, both flags, last legal word.
    do_req(1'b0, 10'd512, 32'd0, 0, 1'b0);
    do_req(1'b0, 10'd514, 32'd0, 0, 1'b0);
    do_req(1'b1, 10'd1020, 32'd3, 0, 1'b0);
    do_req(1'b0, 10'd508, 32'd0, 0, 1'b0);
    // Consumer stall for 5 cycles while requests to word 10 are presented.
    do_req(1'b0, 10'd508, 32'd0, 5, 1'b1);
    do_req(1'b0, 10'h028, 32'd0, 0, 1'b0);

    // Reset during WAIT of a store of 99 to addr 8, just before commit.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 10'd8; req_wdata_i = 32'd99;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wait_ready", 32'(req_ready_o), 32'd1);
    check("rst_wait_valid", 32'(rsp_valid_o), 32'd0);
`ifdef DATA_MEM_PERF_EN
    check("rst_rd_cnt", 32'(rd_cnt_o), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
    check("rst_exc_cnt", 32'(exc_cnt_o), 32'd0);
    m_rd = 0; m_wr = 0; m_exc = 0;
`endif
    do_req(1'b0, 10'd8, 32'd0, 0, 1'b0);

    // Reset while a load response is pending drops it.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd12;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    repeat (LATENCY) @(posedge clk);
    #1;
    check("pre_rst_resp_valid", 32'(rsp_valid_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_resp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_resp_rdata", rsp_rdata_o, 32'd0);
    check("rst_resp_ready", 32'(req_ready_o), 32'd1);
`ifdef DATA_MEM_PERF_EN
    m_rd = 0; m_wr = 0; m_exc = 0;
`endif

    // Randomized mix of legal, misaligned and out-of-range traffic.
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 8)  a = ADDR_W'($urandom_range(0, 1023));
      else if (sel == 8) a = ADDR_W'($urandom_range(512, 1023));
      else               a = (($urandom_range(0, 1) == 0) ? 10'd0 : 10'd508);
      d = $urandom;
      do_req(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3), 1'b0);
    end
`ifdef DATA_MEM_PERF_EN
    check("rd_cnt", 32'(rd_cnt_o), 32'(m_rd));
    check("wr_cnt", 32'(wr_cnt_o), 32'(m_wr));
    check("exc_cnt", 32'(exc_cnt_o), 32'(m_exc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
